wb_write_queue: RTL and testbench
=================================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port alu_valid  input  1  ALU-path write request.
REQ-005 SHALL have ports alu_dest  input  4  and alu_result  input  32, the ALU-path destination and data.
REQ-006 SHALL have port mem_valid  input  1  load-path write request.
REQ-007 SHALL have ports mem_dest  input  4  and mem_data  input  32, the load-path destination and data.
REQ-008 SHALL have port in_ready  output  1  high when at least 2 entries are free.
REQ-009 SHALL have ports src_1, src_2  input  4  hazard query registers.
REQ-010 SHALL have ports pending_1, pending_2  output  1  high when a write to src_1/src_2 is queued or on the output.
REQ-011 SHALL have ports Dest_WB  output  4, Result_WB  output  32 and writeBackEN  output  1, the register-file write port.
REQ-012 SHALL have ports count  output  5 (occupancy), empty  output  1 and overflow  output  1 (sticky).

Function
REQ-013 SHALL hold entries (dest, data) in a circular FIFO with read and write pointers wrapping modulo DEPTH.
REQ-014 SHALL drive in_ready = (count <= DEPTH-2) from registered state only.
REQ-015 SHALL, on an edge with in_ready high, push mem entry then alu entry, so mem is older when both are valid.
REQ-016 SHALL, on an edge with in_ready low, drop any valid request, leave the queue unchanged and set overflow.
REQ-017 SHALL, on each edge with count != 0, pop the head and register it into Dest_WB/Result_WB with writeBackEN=1.
REQ-018 SHALL drive writeBackEN=0 after an edge with count == 0, holding Dest_WB/Result_WB at their last values.
REQ-019 SHALL support push and pop on the same edge, updating count by pushes minus pops.
REQ-020 SHALL give a minimum latency of 2 edges: a push at edge k into an empty queue gives writeBackEN high from edge k+1 to k+2.
REQ-021 SHALL drain at most one entry per cycle, in strict FIFO order.
REQ-022 SHALL keep duplicate destinations as separate entries, each written in order, so the last write wins in the register file.
REQ-023 SHALL compute pending_x combinationally as a match against any valid queue entry dest, or against Dest_WB while writeBackEN=1.
REQ-024 SHALL NOT count same-cycle incoming requests in pending_x.
REQ-025 SHALL drive empty = (count == 0).
REQ-026 SHALL clear overflow only by reset.

Reset
REQ-027 SHALL, while rst=0, force count=0, both pointers=0, writeBackEN=0, Dest_WB=0, Result_WB=0 and overflow=0.
REQ-028 SHALL discard queued entries when reset asserts mid-operation, and emit no write until a new push after rst returns high.
REQ-029 SHALL ignore pushes on the first rising edge coincident with or during rst=0.

Verification
REQ-030 SHALL cover: alu_valid=1, alu_dest=3, alu_result=0xDEADBEEF at edge 0 -> writeBackEN=1, Dest_WB=3, Result_WB=0xDEADBEEF after edge 1 only.
REQ-031 SHALL cover: mem(dest 5, 0x11) and alu(dest 6, 0x22) on the same edge -> writes dest 5 then dest 6 on consecutive cycles.
REQ-032 SHALL cover: DEPTH=4, push 2 entries per cycle with no drain opportunity -> in_ready low at count=3 or 4, the extra push is dropped, overflow=1, and all accepted entries later drain in order.
REQ-033 SHALL cover: dest 7 queued, src_1=7, src_2=8 -> pending_1=1 and pending_2=0 until the cycle after the dest-7 write leaves the output.
REQ-034 SHALL cover: 3 entries queued, then rst pulsed low -> writeBackEN=0, count=0, and no stale write appears after release.
REQ-035 SHALL cover: a continuous 1-per-cycle alu stream for 20 cycles -> pointers wrap, count stays <= 1, and 20 writes are output in order.

Source files
------------

// File: rtl/wb_write_queue.sv
// wb_write_queue: write-back queue in front of the register-file write port.
// The ALU and load paths can each request one write per cycle. Accepted
// requests go into a circular FIFO, and exactly one entry drains per cycle
// into a registered write port.
//
// Ports:
//   clk, rst                   clock; asynchronous active-low reset
//   alu_valid/dest/result      ALU-path write request
//   mem_valid/dest/data        load-path write request (older when both fire)
//   in_ready                   at least two entries free; requests are dropped otherwise
//   src_1/src_2 -> pending_x   hazard query against queued entries and the live output
//   Dest_WB/Result_WB/writeBackEN  register-file write port (registered)
//   count/empty/overflow       occupancy, empty flag, sticky drop flag

module wb_wq_match (
  input  logic       vld,
  input  logic [3:0] dest,
  input  logic [3:0] src_1,
  input  logic [3:0] src_2,
  output logic       hit_1,
  output logic       hit_2
);
  assign hit_1 = vld && (dest == src_1);
  assign hit_2 = vld && (dest == src_2);
endmodule

module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [3:0]  alu_dest,
  input  logic [31:0] alu_result,
  input  logic        mem_valid,
  input  logic [3:0]  mem_dest,
  input  logic [31:0] mem_data,
  output logic        in_ready,
  input  logic [3:0]  src_1,
  input  logic [3:0]  src_2,
  output logic        pending_1,
  output logic        pending_2,
  output logic [3:0]  Dest_WB,
  output logic [31:0] Result_WB,
  output logic        writeBackEN,
  output logic [4:0]  count,
  output logic        empty,
  output logic        overflow
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t [DEPTH-1:0] ent_q;
  logic    [DEPTH-1:0] ent_vld;
  logic    [PW-1:0]    rd_ptr, wr_ptr, alu_slot;
  logic    [4:0]       count_q;
  logic                push_m, push_a, do_pop;
  logic    [1:0]       n_push;
  logic    [DEPTH-1:0] hit_1, hit_2;

  // Admission depends only on registered occupancy. Keeping two entries free
  // guarantees room for a double push even when no pop happens.
  assign in_ready = (count_q <= 5'(DEPTH - 2));
  assign push_m   = in_ready && mem_valid;
  assign push_a   = in_ready && alu_valid;
  assign n_push   = {1'b0, push_m} + {1'b0, push_a};
  // The load entry goes in first, so the ALU entry lands one slot later when both fire.
  assign alu_slot = wr_ptr + PW'(push_m);
  assign do_pop   = (count_q != 5'd0);

  assign count = count_q;
  assign empty = (count_q == 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q       <= '0;
      ent_vld     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      Dest_WB     <= '0;
      Result_WB   <= '0;
      writeBackEN <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // Pop and push slots never collide: pushes only happen with at least
      // two free entries, and a pop only happens when the queue is non-empty.
      if (do_pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        Dest_WB         <= ent_q[rd_ptr].dest;
        Result_WB       <= ent_q[rd_ptr].data;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (push_m) begin
        ent_q[wr_ptr]   <= '{dest: mem_dest, data: mem_data};
        ent_vld[wr_ptr] <= 1'b1;
      end
      if (push_a) begin
        ent_q[alu_slot]   <= '{dest: alu_dest, data: alu_result};
        ent_vld[alu_slot] <= 1'b1;
      end
      writeBackEN <= do_pop;
      wr_ptr      <= wr_ptr + PW'(n_push);
      count_q     <= count_q + 5'(n_push) - 5'(do_pop);
      if (!in_ready && (mem_valid || alu_valid))
        overflow <= 1'b1;
    end
  end

  // Per-entry hazard compare. Incoming requests are deliberately not included.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    wb_wq_match u_match (
      .vld   (ent_vld[i]),
      .dest  (ent_q[i].dest),
      .src_1 (src_1),
      .src_2 (src_2),
      .hit_1 (hit_1[i]),
      .hit_2 (hit_2[i])
    );
  end

  assign pending_1 = (|hit_1) || (writeBackEN && (Dest_WB == src_1));
  assign pending_2 = (|hit_2) || (writeBackEN && (Dest_WB == src_2));

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [3:0]  alu_dest, mem_dest, src_1, src_2;
  logic [31:0] alu_result, mem_data;
  logic        in_ready, pending_1, pending_2;
  logic [3:0]  Dest_WB;
  logic [31:0] Result_WB;
  logic        writeBackEN, empty, overflow;
  logic [4:0]  count;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data),
    .in_ready(in_ready), .src_1(src_1), .src_2(src_2),
    .pending_1(pending_1), .pending_2(pending_2),
    .Dest_WB(Dest_WB), .Result_WB(Result_WB), .writeBackEN(writeBackEN),
    .count(count), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [35:0] sb[$];   // {dest, data} in expected write order
  int mcnt = 0;         // model occupancy
  bit movf = 1'b0;      // model overflow

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests, predict the edge, then check state after it.
  task automatic step(input logic mv, input logic [3:0] md, input logic [31:0] mdt,
                      input logic av, input logic [3:0] ad, input logic [31:0] adt);
    bit acc, pop;
    int np;
    mem_valid = mv; mem_dest = md; mem_data = mdt;
    alu_valid = av; alu_dest = ad; alu_result = adt;
    acc = (mcnt <= DEPTH - 2);
    pop = (mcnt != 0);
    np  = 0;
    #1 chk("in_ready", in_ready, acc);
    if (acc) begin
      if (mv) begin sb.push_back({md, mdt}); np++; end
      if (av) begin sb.push_back({ad, adt}); np++; end
    end else if (mv || av) movf = 1'b1;
    mcnt = mcnt + np - (pop ? 1 : 0);
    @(posedge clk);
    #1;
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("wb_en",    writeBackEN, pop);
    chk("count",    count, mcnt);
    chk("empty",    empty, mcnt == 0);
    chk("overflow", overflow, movf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Scoreboard drain: every output write must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst && writeBackEN) begin
      if (sb.size() == 0) chk("spurious_wb", 1, 0);
      else begin
        logic [35:0] e;
        e = sb.pop_front();
        chk("wb_dest", Dest_WB, e[35:32]);
        chk("wb_data", Result_WB, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    mem_valid = 0; mem_dest = 0; mem_data = 0;
    alu_valid = 1; alu_dest = 4'd9; alu_result = 32'h55;  // push during reset must be ignored
    src_1 = 0; src_2 = 0;
    repeat (2) @(posedge clk);
    #1;
    alu_valid = 0;
    chk("rst_wben",  writeBackEN, 0);
    chk("rst_count", count, 0);
    chk("rst_dest",  Dest_WB, 0);
    chk("rst_res",   Result_WB, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_empty", empty, 1);
    @(negedge clk) rst = 1'b1;

    // single ALU write, 2-edge latency
    step(0, 0, 0, 1, 4'd3, 32'hDEADBEEF);
    idle(3);

    // both paths on one edge: mem is older
    step(1, 4'd5, 32'h11, 1, 4'd6, 32'h22);
    idle(4);

    // hazard tracking
    src_1 = 4'd7; src_2 = 4'd8;
    alu_valid = 1; alu_dest = 4'd8;
    #1 chk("pend_incoming", pending_2, 0);
    alu_valid = 0;
    step(0, 0, 0, 1, 4'd7, 32'h77);
    chk("pend1_queued", pending_1, 1);
    chk("pend2_queued", pending_2, 0);
    idle(1);
    chk("pend1_output", pending_1, 1);
    chk("pend2_output", pending_2, 0);
    idle(1);
    chk("pend1_done", pending_1, 0);

    // double pushes until admission closes; dropped requests set overflow
    for (int i = 0; i < 4; i++)
      step(1, 4'(i), 32'h100 + i, 1, 4'(i + 8), 32'h200 + i);
    idle(6);

    // reset mid-operation with 3 entries queued
    step(1, 4'd1, 32'hA1, 1, 4'd2, 32'hA2);
    step(1, 4'd3, 32'hA3, 1, 4'd4, 32'hA4);
    rst = 1'b0;
    #1;
    chk("midrst_wben",  writeBackEN, 0);
    chk("midrst_count", count, 0);
    chk("midrst_ovf",   overflow, 0);
    sb.delete();
    mcnt = 0; movf = 1'b0;
    @(negedge clk) rst = 1'b1;
    idle(4);

    // continuous stream wraps the pointers
    for (int i = 0; i < 20; i++)
      step(0, 0, 0, 1, 4'(i), $urandom);
    idle(3);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
